// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 5;

    // Floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder from two half-adder stages
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic co
);

    logic p1;
    logic g1;
    logic g2;

    assign p1  = a ^ b;
    assign g1  = a & b;
    assign sum = p1 ^ cin;
    assign g2  = p1 & cin;
    assign co  = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller, one bit per clock LSB first
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int CW = clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum_q;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    full_adder_cell u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .sum (fa_s),
        .co  (fa_co)
    );

    // New bit enters at the MSB so bit i settles in position i after WIDTH shifts.
    assign res_d = (res_q >> 1) | ({{(WIDTH-1){1'b0}}, fa_s} << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    res_q   <= res_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_q <= {fa_co, res_d};
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum = sum_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder/subtractor controller that time-multiplexes a single full-adder cell across a WIDTH-bit operand pair, one bit per clock, LSB first. It is the sequential counterpart of the parallel ripple-carry adder chain: it trades WIDTH adder cells for one cell plus shift registers, a carry flip-flop and a small FSM. Operands are captured on a start pulse. The (WIDTH+1)-bit result is presented with a one-cycle done strobe and held until the next accepted start.

## Interface
Parameters:
- WIDTH, 5, operand width in bits; legal range 2..32

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request to begin an operation; sampled only in IDLE
- sub  in  1  0 = a+b+cin, 1 = a-b (computed as a + ~b + 1; cin ignored)
- cin  in  1  carry-in for add mode
- a  in  WIDTH  operand A, captured when start is accepted
- b  in  WIDTH  operand B, captured when start is accepted
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  one-cycle pulse when sum becomes valid
- sum  out  WIDTH+1  result; sum[WIDTH] = carry-out (sub mode: 1 = no borrow)

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE when the bit counter reaches WIDTH-1.
  - DONE -> IDLE unconditionally.
- Capture on accept:
  - a_sh <= a.
  - b_sh <= sub ? ~b : b.
  - carry <= sub ? 1 : cin.
  - cnt <= 0.
  - busy <= 1.
- Each RUN cycle:
  - Full-adder cell computes s = a_sh[0]^b_sh[0]^carry and co from the same three inputs.
  - carry <= co.
  - a_sh and b_sh shift right by 1.
  - s is shifted into the result register from the MSB side, so bit i lands in sum[i] after WIDTH shifts.
  - cnt <= cnt+1.
- Entering DONE:
  - sum[WIDTH-1:0] <= shifted result.
  - sum[WIDTH] <= final carry.
  - busy <= 0.
  - done <= 1 for exactly one cycle.
- sum is updated only on entry to DONE. It holds its value through IDLE and through the next operation until that operation's DONE.
- start is ignored in RUN and DONE. It is not queued.
- All arithmetic is modulo 2^WIDTH plus the carry bit. There is no overflow flag.

## Timing
- Reset values: busy=0, done=0, sum=0; internal state = IDLE, carry=0, cnt=0.
- Reset (rst_n=0 at a rising edge) aborts any operation. All outputs take their reset values on that edge, and no done is produced for the aborted operation.
- Latency, with start sampled high at edge t:
  - busy=1 from t through t+WIDTH.
  - done=1 during cycle t+WIDTH+1, with sum valid in the same cycle.
  - The earliest next accepted start is at edge t+WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- start and rst_n low together: reset wins.
- busy and done are never high in the same cycle.

## Structure
- Shared package serial_add_pkg:
  - state typedef (IDLE, RUN, DONE);
  - default WIDTH constant;
  - counter-width function clog2(WIDTH).
- Single sub-module full_adder_cell (a, b, cin -> sum, co), built from two half-adder stages plus an OR. It is instantiated once.
- Everything else is registers plus the FSM in the top module.

## Test plan
- Add, WIDTH=5: a=11111, b=01010, sub=0, cin=0, start at edge t -> done at t+6, sum=101001 (41); busy high for 5 cycles.
- Carry-in: a=11111, b=00000, cin=1 -> sum=100000.
- Subtract without borrow: a=01010, b=00011, sub=1 -> sum=100111 (7, no-borrow bit = 1).
- Subtract with borrow: a=00011, b=01010, sub=1 -> sum=011001 (-7 mod 32, bit5 = 0).
- start held high continuously with new a/b values during RUN and DONE:
  - the operands in flight are unchanged;
  - exactly one done per WIDTH+2 cycles;
  - sum is stable between done pulses.
- rst_n=0 for one cycle at the 3rd RUN cycle:
  - busy=0, done=0, sum=0 on the next edge;
  - no done pulse for the aborted operation;
  - a following start (a=00001, b=00001) gives sum=000010.
